// File: rtl/regfile_wb_if.sv
// Writeback, read and issue signals between the pipeline and the register file.
// An issue is accepted in exactly the cycles where issue_valid=1 and stall=0;
// stall is a combinational answer to the presented instruction and may drop mid-cycle.
interface regfile_wb_if #(parameter int Width = 32);
  logic             RegWrite;
  logic [4:0]       rd;
  logic [Width-1:0] Writeback;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [Width-1:0] readData1;
  logic [Width-1:0] readData2;
  logic             issue_valid;
  logic             issue_regwrite;
  logic [4:0]       issue_rd;
  logic             use_rs;
  logic             use_rt;
  logic             stall;
  logic             pend_any;

  modport master (
    output RegWrite, rd, Writeback, rs, rt,
    output issue_valid, issue_regwrite, issue_rd, use_rs, use_rt,
    input  readData1, readData2, stall, pend_any
  );

  modport slave (
    input  RegWrite, rd, Writeback, rs, rt,
    input  issue_valid, issue_regwrite, issue_rd, use_rs, use_rt,
    output readData1, readData2, stall, pend_any
  );
endinterface

// File: rtl/regfile_wb.sv
// Architectural register file with write-to-read bypass and a per-register
// in-flight write scoreboard that stalls decode on pending operands.
module regfile_wb #(
  parameter int Width   = 32,
  parameter int MaxPend = 3
) (
  input logic         clk,
  input logic         rst,
  regfile_wb_if.slave bus
);
  localparam int CW = $clog2(MaxPend + 1);

  // Entry 0 of both arrays is cleared at reset and never written afterwards.
  logic [Width-1:0] regs [32];
  logic [CW-1:0]    cnt  [32];

  logic wb_en;
  logic inc_en;
  logic rs_busy;
  logic rt_busy;
  logic full_hit;

  assign wb_en = bus.RegWrite && (bus.rd != 5'd0);

  // A same-cycle writeback retires one pending write; a zero counter stays at zero.
  always_comb begin
    rs_busy  = 1'b0;
    rt_busy  = 1'b0;
    full_hit = 1'b0;
    if (bus.rs != 5'd0)
      rs_busy = cnt[bus.rs] > ((wb_en && bus.rd == bus.rs) ? CW'(1) : CW'(0));
    if (bus.rt != 5'd0)
      rt_busy = cnt[bus.rt] > ((wb_en && bus.rd == bus.rt) ? CW'(1) : CW'(0));
    if (bus.issue_regwrite && bus.issue_rd != 5'd0)
      full_hit = (cnt[bus.issue_rd] == CW'(MaxPend)) &&
                 !(wb_en && bus.rd == bus.issue_rd);
  end

  always_comb begin
    bus.stall = bus.issue_valid &&
                ((bus.use_rs && rs_busy) || (bus.use_rt && rt_busy) || full_hit);
    inc_en    = bus.issue_valid && !bus.stall && bus.issue_regwrite &&
                (bus.issue_rd != 5'd0);
  end

  always_comb begin
    bus.readData1 = '0;
    bus.readData2 = '0;
    if (!rst && bus.rs != 5'd0)
      bus.readData1 = (bus.RegWrite && bus.rd == bus.rs) ? bus.Writeback : regs[bus.rs];
    if (!rst && bus.rt != 5'd0)
      bus.readData2 = (bus.RegWrite && bus.rd == bus.rt) ? bus.Writeback : regs[bus.rt];
  end

  always_comb begin
    bus.pend_any = 1'b0;
    for (int i = 1; i < 32; i++)
      bus.pend_any = bus.pend_any | (cnt[i] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (wb_en)
        regs[bus.rd] <= bus.Writeback;
      for (int i = 1; i < 32; i++) begin
        if (inc_en && bus.issue_rd == 5'(i) && !(wb_en && bus.rd == 5'(i)))
          cnt[i] <= cnt[i] + CW'(1);
        else if (wb_en && bus.rd == 5'(i) && !(inc_en && bus.issue_rd == 5'(i)) &&
                 cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb.sv
// Randomized and directed bench for regfile_wb against an array-based model
// of register contents and pending-write counts.
module tb_regfile_wb;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_if #(.Width(W)) bus();
  regfile_wb #(.Width(W), .MaxPend(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_regs [32];
  int           m_cnt  [32];

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic [4:0] a);
    if (rst || a == 5'd0) return '0;
    if (bus.RegWrite && bus.rd == a) return bus.Writeback;
    return m_regs[a];
  endfunction

  // Outstanding writes not covered by this cycle's writeback; never below zero.
  function automatic logic m_busy(input logic [4:0] a);
    int eff;
    if (a == 5'd0) return 1'b0;
    eff = m_cnt[a] - ((bus.RegWrite && bus.rd == a) ? 1 : 0);
    return eff > 0;
  endfunction

  task automatic idle();
    bus.RegWrite = 0; bus.rd = 0; bus.Writeback = '0; bus.rs = 0; bus.rt = 0;
    bus.issue_valid = 0; bus.issue_regwrite = 0; bus.issue_rd = 0;
    bus.use_rs = 0; bus.use_rt = 0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [W-1:0] d);
    bus.RegWrite = 1; bus.rd = r; bus.Writeback = d;
  endtask

  task automatic issue(input logic rw, input logic [4:0] r, input logic urs, input logic [4:0] s,
                       input logic urt, input logic [4:0] t);
    bus.issue_valid = 1; bus.issue_regwrite = rw; bus.issue_rd = r;
    bus.use_rs = urs; bus.rs = s; bus.use_rt = urt; bus.rt = t;
  endtask

  // Called just after a rising edge with inputs driven: checks at the falling edge,
  // then advances the model across the next rising edge.
  task automatic run_cycle();
    logic e_stall, e_pend, inc, dec;
    int n_cnt [32];
    logic [W-1:0] n_regs [32];
    @(negedge clk);
    if (rst) model_clear();
    e_stall = bus.issue_valid &&
              ((bus.use_rs && m_busy(bus.rs)) || (bus.use_rt && m_busy(bus.rt)) ||
               (bus.issue_regwrite && bus.issue_rd != 0 && m_cnt[bus.issue_rd] == 3 &&
                !(bus.RegWrite && bus.rd == bus.issue_rd)));
    e_pend = 1'b0;
    for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) e_pend = 1'b1;
    exp_q.push_back(m_read(bus.rs));
    exp_q.push_back(m_read(bus.rt));
    exp_q.push_back({{(W-1){1'b0}}, e_stall});
    exp_q.push_back({{(W-1){1'b0}}, e_pend});
    check_val("readData1", bus.readData1, exp_q.pop_front());
    check_val("readData2", bus.readData2, exp_q.pop_front());
    check_val("stall", {{(W-1){1'b0}}, bus.stall}, exp_q.pop_front());
    check_val("pend_any", {{(W-1){1'b0}}, bus.pend_any}, exp_q.pop_front());
    n_cnt = m_cnt;
    n_regs = m_regs;
    if (!rst) begin
      inc = bus.issue_valid && !e_stall && bus.issue_regwrite && bus.issue_rd != 0;
      dec = bus.RegWrite && bus.rd != 0;
      if (dec) n_regs[bus.rd] = bus.Writeback;
      if (!(inc && dec && bus.issue_rd == bus.rd)) begin
        if (inc) n_cnt[bus.issue_rd]++;
        if (dec && n_cnt[bus.rd] > 0) n_cnt[bus.rd]--;
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_cnt = n_cnt;
      m_regs = n_regs;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then read
    idle(); bus.rs = 5; bus.rt = 0;
    #3;
    check_val("reset_rd1", bus.readData1, '0);
    check_val("reset_pend", {{(W-1){1'b0}}, bus.pend_any}, '0);
    run_cycle();

    // Write with bypass, then from storage, then write to r0
    idle(); wb(7, 32'hDEADBEEF); bus.rs = 7;
    #3; check_val("bypass_r7", bus.readData1, 32'hDEADBEEF);
    run_cycle();
    idle(); bus.rs = 7;
    #3; check_val("stored_r7", bus.readData1, 32'hDEADBEEF);
    run_cycle();
    idle(); wb(0, 32'h1234);
    run_cycle();
    idle(); bus.rs = 0; bus.rt = 0;
    #3; check_val("r0_zero", bus.readData1, '0);
    run_cycle();

    // RAW stall on r3, released by the writeback cycle
    idle(); issue(1, 3, 0, 0, 0, 0); run_cycle();
    idle(); issue(0, 0, 1, 3, 0, 0);
    #3; check_val("raw_stall", {{(W-1){1'b0}}, bus.stall}, 1);
    run_cycle();
    idle(); issue(0, 0, 1, 3, 0, 0); run_cycle();
    idle(); issue(0, 0, 1, 3, 0, 0); wb(3, 32'hCAFE0003);
    #3;
    check_val("raw_release", {{(W-1){1'b0}}, bus.stall}, 0);
    check_val("raw_bypass", bus.readData1, 32'hCAFE0003);
    run_cycle();
    idle(); issue(0, 0, 1, 3, 0, 0); run_cycle();

    // Three pending writers to r9, fourth stalls unless a writeback frees a slot
    for (int i = 0; i < 3; i++) begin
      idle(); issue(1, 9, 0, 0, 0, 0); run_cycle();
    end
    idle(); issue(1, 9, 0, 0, 0, 0);
    #3; check_val("full_stall", {{(W-1){1'b0}}, bus.stall}, 1);
    run_cycle();
    idle(); issue(1, 9, 0, 0, 0, 0); wb(9, 32'h99);
    #3; check_val("full_accept", {{(W-1){1'b0}}, bus.stall}, 0);
    run_cycle();
    idle(); issue(1, 9, 0, 0, 0, 0); run_cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); wb(9, $urandom); run_cycle();
    end

    // Issue to r4 while r6 retires
    idle(); issue(1, 6, 0, 0, 0, 0); run_cycle();
    idle(); issue(1, 4, 0, 0, 0, 0); wb(6, 32'h66); run_cycle();
    idle(); issue(0, 0, 1, 4, 1, 6); run_cycle();
    idle(); wb(4, 32'h44); run_cycle();

    // Asynchronous reset between edges
    idle(); wb(3, 32'h55); run_cycle();
    idle(); issue(1, 3, 0, 0, 0, 0); run_cycle();
    idle(); issue(1, 3, 0, 0, 0, 0); run_cycle();
    idle(); bus.rs = 3;
    #2; rst = 1'b1;
    #1;
    check_val("async_rst_r3", bus.readData1, '0);
    check_val("async_rst_pend", {{(W-1){1'b0}}, bus.pend_any}, '0);
    model_clear();
    run_cycle();
    rst = 1'b0;
    idle(); wb(3, 32'h77); run_cycle();
    idle(); issue(0, 0, 1, 3, 0, 0);
    #3; check_val("stray_wb_nostall", {{(W-1){1'b0}}, bus.stall}, 0);
    run_cycle();

    // Random traffic on a small register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] pick;
      idle();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) != 0) begin
        pick = 5'($urandom_range(0, 7));
        for (int k = 0; k < 8 && $urandom_range(0, 3) != 0; k++) begin
          if (m_cnt[pick] > 0) break;
          pick = 5'($urandom_range(0, 7));
        end
        wb(pick, $urandom);
      end
      bus.rs = 5'($urandom_range(0, 7));
      bus.rt = 5'($urandom_range(0, 7));
      bus.issue_valid    = $urandom_range(0, 1);
      bus.issue_regwrite = $urandom_range(0, 1);
      bus.issue_rd       = 5'($urandom_range(0, 7));
      bus.use_rs         = $urandom_range(0, 1);
      bus.use_rt         = $urandom_range(0, 1);
      run_cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
